maze_pos_tx: RTL and testbench

MAZE_POS_TX -- requirements
Module: maze_pos_tx

---
 rtl/maze_pos_tx_pkg.sv | 40 ++++
 rtl/pos_fifo.sv | 53 +++++
 rtl/maze_pos_tx.sv | 117 +++++++++++
 tb/tb_maze_pos_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pos_tx_pkg.sv
// Shared maze geometry, packet layout and transmitter state encoding.
// The pack/unpack helpers are shared with the display-side receiver.
package maze_pos_tx_pkg;

  localparam int MAZE_ROWS = 4;
  localparam int MAZE_COLS = 5;

  localparam int ROW_W   = 2;
  localparam int COL_W   = 3;
  localparam int PKT_W   = ROW_W + COL_W;
  localparam int ROW_LSB = 0;
  localparam int COL_LSB = ROW_LSB + ROW_W;

  // Wide enough for the largest legal strobe-hold time.
  localparam int CNT_W = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HOLD  = 2'd2
  } tx_state_e;

  function automatic logic [PKT_W-1:0] pack_pos(input logic [COL_W-1:0] col,
                                                input logic [ROW_W-1:0] row);
    logic [PKT_W-1:0] pkt;
    pkt = '0;
    pkt[COL_LSB +: COL_W] = col;
    pkt[ROW_LSB +: ROW_W] = row;
    return pkt;
  endfunction

  function automatic logic [COL_W-1:0] unpack_col(input logic [PKT_W-1:0] pkt);
    return pkt[COL_LSB +: COL_W];
  endfunction

  function automatic logic [ROW_W-1:0] unpack_row(input logic [PKT_W-1:0] pkt);
    return pkt[ROW_LSB +: ROW_W];
  endfunction

endpackage

// File: rtl/pos_fifo.sv
// Small first-in first-out queue for position packets; a push while full is
// dropped even if a pop happens on the same edge.
module pos_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by the count.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/maze_pos_tx.sv
// Queues maze position updates and sends each one to the display FPGA as a
// level packet framed by a setup delay and a long stable strobe.
//   state    | meaning
//   ST_IDLE  | waiting for a queued position; pops it on the next edge
//   ST_SETUP | packet bus settling, strobe low
//   ST_HOLD  | strobe high, packet guaranteed stable
module maze_pos_tx
  import maze_pos_tx_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 25,
  parameter int unsigned HOLD_CYCLES  = 250000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [COL_W-1:0] pos_x,
  input  logic [ROW_W-1:0] pos_y,
  input  logic             pos_valid,
  output logic             pos_ready,
  output logic [PKT_W-1:0] packet_out,
  output logic             packet_strobe,
  output logic             busy,
  output logic             err_range
);

  tx_state_e        state;
  tx_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [PKT_W-1:0] pkt_nxt;
  logic             strobe_nxt;

  logic             accept;
  logic             col_ok;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [PKT_W-1:0] fifo_rdata;

  assign pos_ready = ~fifo_full;
  assign accept    = pos_valid & pos_ready;
  assign col_ok    = (pos_x <= COL_W'(MAZE_COLS - 1));
  assign fifo_push = accept & col_ok;
  assign busy      = (state != ST_IDLE) | ~fifo_empty;

  pos_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   (pack_pos(pos_x, pos_y)),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pkt_nxt    = packet_out;
    strobe_nxt = packet_strobe;
    fifo_pop   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          pkt_nxt   = fifo_rdata;
          cnt_nxt   = CNT_W'(SETUP_CYCLES - 1);
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          strobe_nxt = 1'b1;
          cnt_nxt    = CNT_W'(HOLD_CYCLES - 1);
          state_nxt  = ST_HOLD;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          strobe_nxt = 1'b0;
          state_nxt  = ST_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        strobe_nxt = 1'b0;
        state_nxt  = ST_IDLE;
      end
    endcase
  end

  // Strobe is a flop of its own so the GPIO never sees a state-decode glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      packet_out    <= '0;
      packet_strobe <= 1'b0;
      err_range     <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      packet_out    <= pkt_nxt;
      packet_strobe <= strobe_nxt;
      if (accept && !col_ok) err_range <= 1'b1;
    end
  end

endmodule

// File: tb/tb_maze_pos_tx.sv
// Scoreboard bench for maze_pos_tx: stimulus queues expected packets, an
// independent monitor checks each strobe window against them.
module tb_maze_pos_tx;

  localparam int SETUP = 2;
  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] pos_x = '0;
  logic [1:0] pos_y = '0;
  logic       pos_valid = 1'b0;
  logic       pos_ready;
  logic [4:0] packet_out;
  logic       packet_strobe;
  logic       busy;
  logic       err_range;

  int n_vec  = 0;
  int n_miss = 0;
  int n_rise = 0;
  logic [4:0] sb [$];

  maze_pos_tx #(
    .SETUP_CYCLES (SETUP),
    .HOLD_CYCLES  (HOLD),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .pos_valid     (pos_valid),
    .pos_ready     (pos_ready),
    .packet_out    (packet_out),
    .packet_strobe (packet_strobe),
    .busy          (busy),
    .err_range     (err_range)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the handshake edge.
  task automatic send(input logic [2:0] x, input logic [1:0] y);
    int guard;
    logic [4:0] e;
    guard = 0;
    pos_x = x;
    pos_y = y;
    pos_valid = 1'b1;
    while (!pos_ready && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 2000) chk("ready_timeout", 0, 1);
    e = {x, y};
    if (x <= 3'd4) sb.push_back(e);
    @(negedge clock);
    pos_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || packet_strobe) && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    chk("idle_reached", {31'd0, busy | packet_strobe}, 0);
  endtask

  initial begin : monitor
    logic [4:0] prev_pkt;
    logic       prev_stb;
    logic       moved;
    int         since;
    int         hold_len;
    prev_pkt = '0; prev_stb = 1'b0; moved = 1'b0; since = 0; hold_len = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_pkt = packet_out; prev_stb = 1'b0; moved = 1'b0; since = 0; hold_len = 0;
        continue;
      end
      if (packet_out !== prev_pkt) begin
        since = 0;
        if (packet_strobe || prev_stb) moved = 1'b1;
      end else begin
        since++;
      end
      if (packet_strobe && !prev_stb) begin
        n_rise++;
        chk("setup_settle", {31'd0, since >= SETUP}, 1);
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_packet: got %b expected none", packet_out);
        end else begin
          chk("packet", packet_out, sb.pop_front());
        end
        hold_len = 1;
      end else if (packet_strobe) begin
        hold_len++;
      end else if (prev_stb) begin
        chk("hold_len", hold_len, HOLD);
        chk("hold_stable", {31'd0, moved}, 0);
        moved = 1'b0;
      end
      prev_pkt = packet_out;
      prev_stb = packet_strobe;
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0;
    // reset values
    #12;
    chk("rst_pkt", packet_out, 5'b00000);
    chk("rst_strobe", packet_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_range, 0);
    chk("rst_ready", pos_ready, 1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // single update latency: handshake at E, checks at E+n.5
    send(3'd4, 2'd3);
    @(negedge clock);
    chk("single_pkt", packet_out, 5'b10011);
    chk("single_stb_e1", packet_strobe, 0);
    chk("single_busy", busy, 1);
    @(negedge clock);
    chk("single_stb_e2", packet_strobe, 0);
    @(negedge clock);
    chk("single_stb_e3", packet_strobe, 1);
    repeat (3) @(negedge clock);
    chk("single_stb_e6", packet_strobe, 1);
    @(negedge clock);
    chk("single_stb_e7", packet_strobe, 0);
    @(negedge clock);
    chk("single_busy_e8", busy, 0);

    // out-of-range column is consumed but never sent
    send(3'd5, 2'd1);
    repeat (10) @(negedge clock);
    chk("range_err", err_range, 1);
    chk("range_pkt_kept", packet_out, 5'b10011);
    chk("range_no_busy", busy, 0);
    send(3'd2, 2'd1);
    wait_idle();
    chk("range_next_pkt", packet_out, 5'b01001);
    chk("range_err_sticky", err_range, 1);

    // burst fills the queue, then a sixth waits for space
    send(3'd0, 2'd0);
    send(3'd1, 2'd1);
    send(3'd2, 2'd2);
    send(3'd3, 2'd3);
    send(3'd4, 2'd0);
    chk("burst_full_ready", pos_ready, 0);
    chk("burst_busy", busy, 1);
    send(3'd0, 2'd1);
    wait_idle();
    chk("burst_last_pkt", packet_out, 5'b00001);

    // identical positions are each transmitted
    r0 = n_rise;
    send(3'd2, 2'd2);
    send(3'd2, 2'd2);
    wait_idle();
    chk("dup_count", n_rise - r0, 2);

    // reset two cycles into HOLD with two entries queued
    send(3'd1, 2'd2);
    send(3'd3, 2'd1);
    send(3'd0, 2'd3);
    begin
      int guard;
      guard = 0;
      while (!packet_strobe && guard < 100) begin
        @(negedge clock);
        guard++;
      end
      chk("strobe_seen", packet_strobe, 1);
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("abort_pkt", packet_out, 5'b00000);
    chk("abort_strobe", packet_strobe, 0);
    chk("abort_busy", busy, 0);
    sb.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    r0 = n_rise;
    repeat (20) @(negedge clock);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_pkt", packet_out, 5'b00000);
    chk("post_rst_no_tx", n_rise - r0, 0);
    chk("post_rst_err", err_range, 0);

    // random legal traffic for hold-stability checking
    for (int i = 0; i < 1000; i++) begin
      send(3'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    wait_idle();
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
